// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: one single-port synchronous RAM shared between VGA scan-out
// reads (absolute priority during active video) and a pixel writer using the idle slots.
module vga_fb_arbiter #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 19,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic [10:0]       next_pixel_h,
    input  logic [10:0]       next_pixel_v,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              wr_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid
);
    localparam int unsigned COORD_W = 11;
    localparam logic [COORD_W-1:0] H_LIM     = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_LIM     = COORD_W'(V_ACTIVE);
    localparam logic [ADDR_W-1:0]  PIX_TOTAL = ADDR_W'(H_ACTIVE * V_ACTIVE);

    // State names the RAM action issued in the current cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              wr_ack_q, wr_ack_d;
    logic              wr_err_q, wr_err_d;
    logic              rd_v2_q, rd_v2_d;
    logic [DATA_W-1:0] pix_data_q, pix_data_d;
    logic              pix_valid_q, pix_valid_d;

    logic disp_slot_c;
    logic vblank_c;
    logic wr_in_range_c;

    assign disp_slot_c   = (next_pixel_h < H_LIM) && (next_pixel_v < V_LIM);
    assign vblank_c      = (next_pixel_v >= V_LIM);
    assign wr_in_range_c = (wr_addr < PIX_TOTAL);

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            disp_addr_q <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            wr_ack_q    <= 1'b0;
            wr_err_q    <= 1'b0;
            rd_v2_q     <= 1'b0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            disp_addr_q <= disp_addr_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            wr_ack_q    <= wr_ack_d;
            wr_err_q    <= wr_err_d;
            rd_v2_q     <= rd_v2_d;
            pix_data_q  <= pix_data_d;
            pix_valid_q <= pix_valid_d;
        end
    end

    always_comb begin
        state_d     = IDLE;
        disp_addr_d = disp_addr_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        wr_ack_d    = 1'b0;
        wr_err_d    = 1'b0;

        if (disp_slot_c) begin
            state_d    = READ;
            mem_addr_d = disp_addr_q;
        end else if (wr_req) begin
            // Out-of-range writes are acknowledged but never reach the RAM.
            state_d     = WRITE;
            mem_addr_d  = wr_addr;
            mem_wdata_d = wr_data;
            wr_ack_d    = 1'b1;
            mem_we_d    = wr_in_range_c;
            wr_err_d    = !wr_in_range_c;
        end

        // Raster-order counter replaces v*H_ACTIVE+h.
        if (vblank_c) begin
            disp_addr_d = '0;
        end else if (disp_slot_c) begin
            disp_addr_d = disp_addr_q + ADDR_W'(1);
        end

        // READ in state_q means the address is at the RAM; data returns next cycle.
        rd_v2_d     = (state_q == READ);
        pix_valid_d = rd_v2_q;
        pix_data_d  = rd_v2_q ? mem_rdata : '0;
    end

    assign wr_ack    = wr_ack_q;
    assign wr_err    = wr_err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign pix_data  = pix_data_q;
    assign pix_valid = pix_valid_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter on a reduced 64x48 raster (80x52 total) with a RAM model,
// a frame-level reference model checked every cycle, and literal spot checks.
module tb_vga_fb_arbiter;
    localparam int H  = 64;
    localparam int V  = 48;
    localparam int HT = 80;
    localparam int VT = 52;
    localparam int N  = H * V;
    localparam int DW = 8;
    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          rst;
    logic [10:0]   h_c, v_c;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack, wr_err, mem_we, pix_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata, pix_data;

    always #5 clk = ~clk;

    vga_fb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .vga_clk     (clk),
        .reset       (rst),
        .next_pixel_h(h_c),
        .next_pixel_v(v_c),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .wr_err      (wr_err),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid)
    );

    // Single-port synchronous RAM (read-before-write)
    logic [DW-1:0] ram [0:4095];
    always @(posedge clk) begin
        mem_rdata <= ram[mem_addr[11:0]];
        if (mem_we) ram[mem_addr[11:0]] <= mem_wdata;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Writer: queue of pending writes, popped when the ack is seen.
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;
    wr_t wq[$];
    int  hc, vc;

    task automatic drive();
        h_c    = 11'(hc);
        v_c    = 11'(vc);
        wr_req = (wq.size() > 0);
        if (wq.size() > 0) begin
            wr_addr = wq[0].a;
            wr_data = wq[0].d;
        end
    endtask

    task automatic push_wr(input int a, input int d);
        wr_t e;
        e.a = AW'(a);
        e.d = DW'(d);
        wq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (wr_ack && wq.size() > 0) wq.delete(0);
        hc++;
        if (hc == HT) begin
            hc = 0;
            vc = (vc == VT - 1) ? 0 : vc + 1;
        end
        drive();
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_to(input int h, input int v);
        while (!(hc == h && vc == v)) tick();
    endtask

    // Reference model: frame image, pixel pipeline queue, previous-cycle arbitration.
    typedef struct {
        bit            v;
        bit            known;
        logic [DW-1:0] d;
    } px_t;
    px_t           pq[$];
    logic [DW-1:0] gold [0:N-1];
    bit            synced;
    bit            p_disp, p_grant, p_inr, p_known;
    int            p_addr;
    logic [DW-1:0] p_data;
    int            ea;
    bit            ea_known;
    int            ack_cnt, pv_cnt;

    always @(negedge clk) begin
        px_t e, px;
        int  hh, vv;
        bit  disp;
        if (rst) begin
            check("rst_wr_ack", int'(wr_ack), 0);
            check("rst_wr_err", int'(wr_err), 0);
            check("rst_mem_we", int'(mem_we), 0);
            check("rst_mem_addr", int'(mem_addr), 0);
            check("rst_pix_valid", int'(pix_valid), 0);
            check("rst_pix_data", int'(pix_data), 0);
            e.v = 1'b0; e.known = 1'b1; e.d = '0;
            pq = {e, e, e};
            p_disp = 1'b0; p_grant = 1'b0; p_inr = 1'b0;
            ea = 0; ea_known = 1'b1; synced = 1'b0;
        end else begin
            if (p_disp) begin
                ea = p_addr; ea_known = p_known;
            end else if (p_grant) begin
                ea = p_addr; ea_known = 1'b1;
            end
            check("wr_ack", int'(wr_ack), int'(p_grant));
            check("wr_err", int'(wr_err), int'(p_grant && !p_inr));
            check("mem_we", int'(mem_we), int'(p_grant && p_inr));
            if (ea_known) check("mem_addr", int'(mem_addr), ea);
            if (p_grant && p_inr) check("mem_wdata", int'(mem_wdata), int'(p_data));
            px = pq.pop_front();
            check("pix_valid", int'(pix_valid), int'(px.v));
            if (!px.v) check("pix_data_blank", int'(pix_data), 0);
            else if (px.known) check("pix_data", int'(pix_data), int'(px.d));
            if (wr_ack) ack_cnt++;
            if (pix_valid) pv_cnt++;

            hh   = int'(h_c);
            vv   = int'(v_c);
            disp = (hh < H) && (vv < V);
            if (vv >= V) synced = 1'b1;
            p_disp  = disp;
            p_known = synced;
            p_addr  = vv * H + hh;
            p_grant = !disp && wr_req;
            p_inr   = int'(wr_addr) < N;
            if (p_grant) begin
                p_addr = int'(wr_addr);
                p_data = wr_data;
                if (p_inr) gold[int'(wr_addr)] = wr_data;
            end
            e.v     = disp;
            e.known = synced;
            e.d     = disp ? gold[vv * H + hh] : '0;
            pq.push_back(e);
        end
    end

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = DW'(i);
        for (int i = 0; i < N; i++) gold[i] = DW'(i);
        wr_addr = '0;
        wr_data = '0;
        rst = 1'b1;
        hc = 20; vc = 50;
        drive();
        tick();
        check("init_mem_addr", int'(mem_addr), 0);
        check("init_pix_valid", int'(pix_valid), 0);
        tick(); tick();
        rst = 1'b0;

        // Frame A: scan-out addresses and pixel data
        wait_to(0, 0);
        wait_to(2, 0); settle();
        check("l0_mem_addr_h1", int'(mem_addr), 1);
        check("l0_h2_pix_valid", int'(pix_valid), 0);
        wait_to(8, 0); settle();
        check("l0_h5_pix", int'(pix_data), 8'h05);
        check("l0_h5_valid", int'(pix_valid), 1);
        wait_to(1, 1); settle();
        check("l1_start_addr", int'(mem_addr), 64);
        wait_to(66, 3); settle();
        check("l3_last_pix", int'(pix_data), 8'hFF);
        wait_to(3, 4); settle();
        check("l4_first_pix", int'(pix_data), 8'h00);
        check("l4_first_valid", int'(pix_valid), 1);

        // Write stalled by active video, granted at the first blank slot
        wait_to(20, 5);
        push_wr(1234, 8'h5A);
        drive();
        wait_to(64, 5); settle();
        check("stall_ack", int'(wr_ack), 0);
        tick(); settle();
        check("grant_ack", int'(wr_ack), 1);
        check("grant_we", int'(mem_we), 1);
        check("grant_addr", int'(mem_addr), 1234);
        check("grant_wdata", int'(mem_wdata), 8'h5A);
        check("grant_pix_kept", int'(pix_data), 8'h7E);
        tick(); settle();
        check("grant_ack_pulse", int'(wr_ack), 0);

        // Back-to-back writes in vertical blank
        wait_to(10, 48);
        for (int i = 0; i < 4; i++) push_wr(10 + i, 8'hC0 + i);
        drive();
        for (int i = 0; i < 4; i++) begin
            tick(); settle();
            check("b2b_ack", int'(wr_ack), 1);
            check("b2b_we", int'(mem_we), 1);
            check("b2b_addr", int'(mem_addr), 10 + i);
            check("b2b_wdata", int'(mem_wdata), 8'hC0 + i);
        end
        tick(); settle();
        check("b2b_done_ack", int'(wr_ack), 0);
        check("b2b_done_we", int'(mem_we), 0);

        // Out-of-range write, then last legal address
        wait_to(0, 49);
        push_wr(N, 8'h11);
        push_wr(N - 1, 8'h22);
        drive();
        tick(); settle();
        check("oor_ack", int'(wr_ack), 1);
        check("oor_err", int'(wr_err), 1);
        check("oor_we", int'(mem_we), 0);
        tick(); settle();
        check("last_ack", int'(wr_ack), 1);
        check("last_err", int'(wr_err), 0);
        check("last_we", int'(mem_we), 1);
        check("last_addr", int'(mem_addr), N - 1);

        // Frame B: writer holds wr_req for a full frame
        wait_to(0, 0);
        for (int i = 0; i < 1200; i++) push_wr(i % N, i * 7 + 3);
        drive();
        ack_cnt = 0;
        pv_cnt  = 0;
        repeat (HT * VT) tick();
        settle();
        check("frame_write_slots", ack_cnt, HT * VT - N);
        check("frame_pix_valid", pv_cnt, N);

        // Frame C: reset mid-line with a stalled write pending
        wait_to(20, 2);
        rst = 1'b1;
        #1;
        check("async_rst_ack", int'(wr_ack), 0);
        check("async_rst_we", int'(mem_we), 0);
        check("async_rst_addr", int'(mem_addr), 0);
        check("async_rst_pv", int'(pix_valid), 0);
        check("async_rst_wdata", int'(mem_wdata), 0);
        tick(); tick(); tick();
        rst = 1'b0;
        wait_to(25, 2); settle();
        check("post_rst_pv_h25", int'(pix_valid), 0);
        tick(); settle();
        check("post_rst_pv_h26", int'(pix_valid), 1);
        wait_to(64, 2); settle();
        check("post_rst_no_ack", int'(wr_ack), 0);
        tick(); settle();
        check("post_rst_reissue_ack", int'(wr_ack), 1);

        // Frame D: scan-out resynchronised after vertical blank
        wait_to(0, 0);
        wait_to(10, 2);
        settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
